// File: rtl/timer_tick_master.sv
// ---------------------------------------------------------------------------
// timer_tick_master
//
// Avalon-MM initiator for a 16-bit interval-timer slave (status 0, control 1,
// period_l 2, period_h 3). A command from the player sequencer carries a period
// and a tick count. The block programs the timer, starts it in continuous mode
// with the interrupt enabled, and services every IRQ by clearing the status
// register. Each serviced IRQ is turned into a one-cycle tick pulse, so the
// note/sample sequencer advances without any CPU interrupt handler.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   cmd_valid/ready  command handshake. cmd_ready is high only in IDLE.
//                    A command is taken on a cycle where both are high.
//                    Commands that arrive while busy are not queued.
//   cmd_period       timer period in clocks minus 1 (clamped up to PERIOD_MIN)
//   cmd_count        ticks to deliver before auto-stop, 0 = run until stop_req
//   stop_req         level, sampled only while waiting for an IRQ
//   avm_*            Avalon-MM initiator port. All outputs are registered.
//                    No waitrequest, so every access lasts one cycle.
//   avm_readdata     registered slave data, valid the cycle after a read
//   avm_irq          timer interrupt level
//   tick             one-cycle pulse per serviced IRQ
//   tick_cnt         ticks delivered in the current run
//   busy             FSM is not in IDLE
//   done             one-cycle pulse as a run ends
//   err              sticky: the run bit was clear after start. Cleared on
//                    the next command accept.
// ---------------------------------------------------------------------------
module timer_tick_master #(
    parameter int          CNT_W      = 16,
    parameter logic [31:0] PERIOD_MIN = 32'd1,
    parameter bit          CHECK_RUN  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_period,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             stop_req,
    output logic [2:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [15:0]      avm_writedata,
    input  logic [15:0]      avm_readdata,
    input  logic             avm_irq,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // One Avalon access per state; only WAIT_IRQ may last longer than a cycle.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_PL    = 4'd1,
        WR_PH    = 4'd2,
        WR_CTRL  = 4'd3,
        RD_STAT  = 4'd4,
        CHK_STAT = 4'd5,
        WAIT_IRQ = 4'd6,
        CLR_IRQ  = 4'd7,
        STOP_WR  = 4'd8,
        CLR_FIN  = 4'd9
    } state_t;

    // Timer register map
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

    // Control words: START|CONT|ITO to launch, STOP alone (ITO=0, CONT=0) to halt
    localparam logic [15:0] CTRL_START = 16'h0007;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;
    // Any write to status clears the timeout flag and so drops the IRQ
    localparam logic [15:0] STATUS_CLR = 16'h0000;

    state_t state;
    state_t state_next;

    logic [31:0]      period_q;
    logic [CNT_W-1:0] count_q;

    logic             accept;
    logic [31:0]      period_clamped;
    logic [CNT_W-1:0] tick_cnt_inc;
    logic             count_reached;
    logic             run_bit;

    // Values the registered Avalon/strobe outputs take for the upcoming state
    logic             cs_next;
    logic             write_n_next;
    logic [2:0]       addr_next;
    logic [15:0]      wdata_next;
    logic             tick_next;
    logic             done_next;

    // Only the run bit of the status register matters here
    logic             unused_readdata;

    assign cmd_ready       = (state == IDLE);
    assign busy            = (state != IDLE);
    assign accept          = cmd_valid && cmd_ready;
    assign period_clamped  = (cmd_period < PERIOD_MIN) ? PERIOD_MIN : cmd_period;
    assign tick_cnt_inc    = tick_cnt + CNT_W'(1);
    // count_q == 0 means free-running, so the increment simply wraps
    assign count_reached   = (count_q != '0) && (tick_cnt_inc == count_q);
    assign run_bit         = avm_readdata[1];
    assign unused_readdata = ^{avm_readdata[15:2], avm_readdata[0]};

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 3'd0;
            avm_writedata  <= 16'h0000;
            tick           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            tick_cnt       <= '0;
            period_q       <= 32'd0;
            count_q        <= '0;
        end else begin
            state          <= state_next;
            avm_chipselect <= cs_next;
            avm_write_n    <= write_n_next;
            avm_address    <= addr_next;
            avm_writedata  <= wdata_next;
            tick           <= tick_next;
            done           <= done_next;

            if (accept) begin
                period_q <= period_clamped;
                count_q  <= cmd_count;
                tick_cnt <= '0;
                err      <= 1'b0;
            end

            if (state == CLR_IRQ) begin
                tick_cnt <= tick_cnt_inc;
            end

            // Readdata here is the response to the status read issued in RD_STAT
            if ((state == CHK_STAT) && !run_bit) begin
                err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and the bus access belonging to that next state.
    // The access is decoded from state_next so that the registered bus
    // outputs line up with the state that owns the access.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        cs_next      = 1'b0;
        write_n_next = 1'b1;
        addr_next    = ADDR_STATUS;
        wdata_next   = 16'h0000;
        tick_next    = 1'b0;
        done_next    = 1'b0;

        unique case (state)
            IDLE:     if (accept) state_next = WR_PL;
            WR_PL:    state_next = WR_PH;
            WR_PH:    state_next = WR_CTRL;
            WR_CTRL:  state_next = CHECK_RUN ? RD_STAT : WAIT_IRQ;
            RD_STAT:  state_next = CHK_STAT;
            CHK_STAT: state_next = run_bit ? WAIT_IRQ : STOP_WR;
            WAIT_IRQ: begin
                // A stop request wins over a simultaneous IRQ; that tick is dropped
                if (stop_req) begin
                    state_next = STOP_WR;
                end else if (avm_irq) begin
                    state_next = CLR_IRQ;
                end
            end
            CLR_IRQ:  state_next = count_reached ? STOP_WR : WAIT_IRQ;
            STOP_WR:  state_next = CLR_FIN;
            CLR_FIN:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        case (state_next)
            WR_PL: begin
                // Only reachable from IDLE on accept, before period_q is loaded
                cs_next      = 1'b1;
                write_n_next = 1'b0;
                addr_next    = ADDR_PERIOD_L;
                wdata_next   = period_clamped[15:0];
            end
            WR_PH: begin
                cs_next      = 1'b1;
                write_n_next = 1'b0;
                addr_next    = ADDR_PERIOD_H;
                wdata_next   = period_q[31:16];
            end
            WR_CTRL: begin
                cs_next      = 1'b1;
                write_n_next = 1'b0;
                addr_next    = ADDR_CONTROL;
                wdata_next   = CTRL_START;
            end
            RD_STAT: begin
                cs_next      = 1'b1;
                write_n_next = 1'b1;
                addr_next    = ADDR_STATUS;
            end
            CLR_IRQ: begin
                cs_next      = 1'b1;
                write_n_next = 1'b0;
                addr_next    = ADDR_STATUS;
                wdata_next   = STATUS_CLR;
                tick_next    = 1'b1;
            end
            STOP_WR: begin
                cs_next      = 1'b1;
                write_n_next = 1'b0;
                addr_next    = ADDR_CONTROL;
                wdata_next   = CTRL_STOP;
            end
            CLR_FIN: begin
                cs_next      = 1'b1;
                write_n_next = 1'b0;
                addr_next    = ADDR_STATUS;
                wdata_next   = STATUS_CLR;
                done_next    = 1'b1;
            end
            default: begin
                cs_next      = 1'b0;
                write_n_next = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_tick_master.sv
// ---------------------------------------------------------------------------
// tb_timer_tick_master
//
// Drives timer_tick_master against a behavioural interval-timer slave.
// Each run is modelled as the bus transaction list it must produce, which
// follows from the period, the number of ticks and the way the run ends,
// together with the expected tick spacing (period+1 clocks) and the final
// tick_cnt. Valid/ready: a command is taken on a rising edge where
// cmd_valid and cmd_ready are both high.
// ---------------------------------------------------------------------------
module tb_timer_tick_master;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_period = 32'd0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             stop_req = 1'b0;
    logic [2:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic [15:0]      avm_writedata;
    logic [15:0]      avm_readdata;
    logic             avm_irq;
    logic             tick;
    logic [CNT_W-1:0] tick_cnt;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_tick_master #(
        .CNT_W      (CNT_W),
        .PERIOD_MIN (32'd1),
        .CHECK_RUN  (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_period     (cmd_period),
        .cmd_count      (cmd_count),
        .stop_req       (stop_req),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_irq        (avm_irq),
        .tick           (tick),
        .tick_cnt       (tick_cnt),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // ------------------------------------------------------------------
    // Interval-timer slave model
    // ------------------------------------------------------------------
    logic [31:0] t_period = 32'd0;
    logic [31:0] t_cnt = 32'd0;
    logic        t_run = 1'b0;
    logic        t_to = 1'b0;
    logic        t_ito = 1'b0;
    logic        t_cont = 1'b0;
    logic [15:0] t_rdata = 16'd0;
    logic        force_norun = 1'b0;
    logic        irq_force = 1'b0;

    assign avm_readdata = t_rdata;
    assign avm_irq      = (t_to & t_ito) | irq_force;

    always @(posedge clk) begin : timer_model
        logic [31:0] per_n, cnt_n;
        logic        run_n, to_n, ito_n, cont_n, wr;
        per_n  = t_period;
        cnt_n  = t_cnt;
        run_n  = t_run;
        to_n   = t_to;
        ito_n  = t_ito;
        cont_n = t_cont;
        wr     = (avm_chipselect === 1'b1) && (avm_write_n === 1'b0);
        if (wr && avm_address == 3'd0) to_n = 1'b0;
        if (t_run) begin
            if (t_cnt == 32'd0) begin
                to_n  = 1'b1;
                cnt_n = t_period;
                if (!t_cont) run_n = 1'b0;
            end else begin
                cnt_n = t_cnt - 32'd1;
            end
        end
        if (wr) begin
            case (avm_address)
                3'd2: begin per_n[15:0]  = avm_writedata; run_n = 1'b0; end
                3'd3: begin per_n[31:16] = avm_writedata; run_n = 1'b0; end
                3'd1: begin
                    ito_n  = avm_writedata[0];
                    cont_n = avm_writedata[1];
                    if (avm_writedata[3]) run_n = 1'b0;
                    if (avm_writedata[2]) begin run_n = 1'b1; cnt_n = per_n; end
                end
                default: ;
            endcase
        end
        if ((avm_chipselect === 1'b1) && (avm_write_n === 1'b1) && avm_address == 3'd0)
            t_rdata <= {14'd0, t_run & ~force_norun, t_to};
        else
            t_rdata <= 16'd0;
        t_period <= per_n;
        t_cnt    <= cnt_n;
        t_run    <= run_n;
        t_to     <= to_n;
        t_ito    <= ito_n;
        t_cont   <= cont_n;
    end

    // ------------------------------------------------------------------
    // Bus / strobe monitor (samples away from the active edge)
    // Transaction encoding: {is_write, address, writedata or 0 for reads}
    // ------------------------------------------------------------------
    logic [19:0] obs_q[$];
    int          obs_cyc[$];
    int          tick_times[$];
    int          cyc = 0;
    int          tick_seen = 0;
    int          done_seen = 0;
    int          overlap = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (avm_chipselect === 1'b1) begin
            obs_q.push_back({~avm_write_n, avm_address, avm_write_n ? 16'd0 : avm_writedata});
            obs_cyc.push_back(cyc);
        end
        if (tick === 1'b1) begin
            tick_seen = tick_seen + 1;
            tick_times.push_back(cyc);
        end
        if (done === 1'b1) done_seen = done_seen + 1;
        if (tick === 1'b1 && done === 1'b1) overlap = overlap + 1;
    end

    // ------------------------------------------------------------------
    // Reference model: expected transactions for one run
    // ------------------------------------------------------------------
    logic [19:0] exp_q[$];
    logic [19:0] diff_got;
    logic [19:0] diff_exp;

    function automatic logic [31:0] eff_period(input logic [31:0] p);
        return (p < 32'd1) ? 32'd1 : p;
    endfunction

    task automatic build_exp(input logic [31:0] p, input int nticks);
        logic [31:0] e;
        e = eff_period(p);
        exp_q.delete();
        exp_q.push_back({1'b1, 3'd2, e[15:0]});
        exp_q.push_back({1'b1, 3'd3, e[31:16]});
        exp_q.push_back({1'b1, 3'd1, 16'h0007});
        exp_q.push_back({1'b0, 3'd0, 16'h0000});
        for (int i = 0; i < nticks; i++) exp_q.push_back({1'b1, 3'd0, 16'h0000});
        exp_q.push_back({1'b1, 3'd1, 16'h0008});
        exp_q.push_back({1'b1, 3'd0, 16'h0000});
    endtask

    // -1: match, -2: length differs, else index of first differing transaction
    function automatic int bus_diff(input int base);
        if (obs_q.size() - base != exp_q.size()) begin
            diff_got = 20'(obs_q.size() - base);
            diff_exp = 20'(exp_q.size());
            return -2;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_q[base + i] !== exp_q[i]) begin
                diff_got = obs_q[base + i];
                diff_exp = exp_q[i];
                return i;
            end
        end
        return -1;
    endfunction

    // 0 when every gap between ticks after tbase equals gap, else the first bad gap
    function automatic int first_bad_gap(input int tbase, input int gap);
        for (int i = tbase + 1; i < tick_times.size(); i++)
            if (tick_times[i] - tick_times[i-1] != gap) return tick_times[i] - tick_times[i-1];
        return 0;
    endfunction

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [31:0] p, input logic [CNT_W-1:0] c, output int acc_cyc);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin step(1); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
        end
        cmd_period = p;
        cmd_count  = c;
        cmd_valid  = 1'b1;
        acc_cyc    = cyc;
        step(1);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int base, n;
        base = done_seen;
        n = 0;
        while (done_seen == base && n < budget) begin step(1); n++; end
        checks++;
        if (done_seen == base) begin
            errors++;
            $display("FAIL %s done_timeout got=no_done exp=done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_ticks(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (tick_seen < target && n < budget) begin step(1); n++; end
        checks++;
        if (tick_seen < target) begin
            errors++;
            $display("FAIL %s tick_timeout got=%0d exp=%0d", name, tick_seen, target);
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        int obase;
        reset = 1'b1;
        step(3);
        checks++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 3'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_bus got=cs%b wn%b a%0d d%h exp=cs0 wn1 a0 d0000",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        checks++;
        if ({tick, done, err, busy, cmd_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00001 (tick done err busy ready)", {tick, done, err, busy, cmd_ready});
        end
        checks++;
        if (tick_cnt !== '0) begin
            errors++;
            $display("FAIL reset_tick_cnt got=%0d exp=0", tick_cnt);
        end
        reset = 1'b0;
        // stop_req in IDLE has no effect
        obase = obs_q.size();
        stop_req = 1'b1;
        step(5);
        stop_req = 1'b0;
        checks++;
        if (busy !== 1'b0 || obs_q.size() != obase) begin
            errors++;
            $display("FAIL idle_stop_req got=busy%b txns%0d exp=busy0 txns0", busy, obs_q.size() - obase);
        end
    endtask

    // T1 with a shortened period so the run stays brief; high half still checked as 0000
    task automatic test_basic();
        int obase, tbase, dbase, acc, r, g;
        logic [31:0] p;
        p = 32'h0000_034F;
        obase = obs_q.size(); tbase = tick_seen; dbase = done_seen;
        build_exp(p, 3);
        send_cmd(p, 16'd3, acc);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL t1_busy got=busy%b ready%b exp=busy1 ready0", busy, cmd_ready);
        end
        // A command offered while busy must be ignored
        step(8);
        cmd_valid = 1'b1; cmd_period = 32'd5; cmd_count = 16'd1;
        step(2);
        cmd_valid = 1'b0;
        wait_done(3 * 848 + 100, "t1");
        r = bus_diff(obase);
        checks++;
        if (r != -1) begin
            errors++;
            $display("FAIL t1_bus idx=%0d got=%h exp=%h", r, diff_got, diff_exp);
        end
        checks++;
        if (obs_cyc.size() > obase + 2 && obs_cyc[obase + 2] != acc + 3) begin
            errors++;
            $display("FAIL t1_start_latency got=%0d exp=%0d", obs_cyc[obase + 2] - acc, 3);
        end
        checks++;
        if (tick_seen - tbase != 3 || tick_cnt !== 16'd3) begin
            errors++;
            $display("FAIL t1_ticks got=pulses%0d cnt%0d exp=pulses3 cnt3", tick_seen - tbase, tick_cnt);
        end
        g = first_bad_gap(tbase, 848);
        checks++;
        if (g != 0) begin
            errors++;
            $display("FAIL t1_tick_gap got=%0d exp=848", g);
        end
        step(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_seen - dbase != 1) begin
            errors++;
            $display("FAIL t1_done_pulse got=done%b busy%b pulses%0d exp=done0 busy0 pulses1",
                     done, busy, done_seen - dbase);
        end
    endtask

    task automatic test_period_clamp();
        int obase, tbase, acc, r, g;
        obase = obs_q.size(); tbase = tick_seen;
        build_exp(32'd0, 4);
        send_cmd(32'd0, 16'd4, acc);
        wait_done(200, "t2");
        r = bus_diff(obase);
        checks++;
        if (r != -1) begin
            errors++;
            $display("FAIL t2_bus idx=%0d got=%h exp=%h", r, diff_got, diff_exp);
        end
        g = first_bad_gap(tbase, 2);
        checks++;
        if (g != 0 || tick_seen - tbase != 4) begin
            errors++;
            $display("FAIL t2_ticks got=gap%0d pulses%0d exp=gap0ok pulses4", g, tick_seen - tbase);
        end
    endtask

    task automatic test_continuous_stop();
        int obase, tbase, acc, r, g;
        obase = obs_q.size(); tbase = tick_seen;
        build_exp(32'd9, 5);
        send_cmd(32'd9, 16'd0, acc);
        wait_ticks(tbase + 5, 200, "t3");
        stop_req = 1'b1;
        wait_done(50, "t3");
        stop_req = 1'b0;
        r = bus_diff(obase);
        checks++;
        if (r != -1) begin
            errors++;
            $display("FAIL t3_bus idx=%0d got=%h exp=%h", r, diff_got, diff_exp);
        end
        g = first_bad_gap(tbase, 10);
        checks++;
        if (g != 0) begin
            errors++;
            $display("FAIL t3_tick_gap got=%0d exp=10", g);
        end
        checks++;
        if (tick_cnt !== 16'd5) begin
            errors++;
            $display("FAIL t3_tick_cnt got=%0d exp=5", tick_cnt);
        end
    endtask

    task automatic test_stop_beats_irq();
        int obase, tbase, acc, r, k;
        obase = obs_q.size(); tbase = tick_seen;
        build_exp(32'd1000, 2);
        send_cmd(32'd1000, 16'd0, acc);
        step(10);
        for (int i = 0; i < 2; i++) begin
            irq_force = 1'b1;
            k = cyc;
            step(1);
            irq_force = 1'b0;
            checks++;
            if (tick !== 1'b1) begin
                errors++;
                $display("FAIL t4_irq_to_tick got=tick%b at +1 exp=tick1 (irq at cycle %0d)", tick, k);
            end
            step(3);
        end
        stop_req  = 1'b1;
        irq_force = 1'b1;
        step(1);
        irq_force = 1'b0;
        stop_req  = 1'b0;
        checks++;
        if (tick !== 1'b0 || {avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin
            errors++;
            $display("FAIL t4_stop_wins got=tick%b cs%b wn%b a%0d d%h exp=tick0 cs1 wn0 a1 d0008",
                     tick, avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        wait_done(20, "t4");
        r = bus_diff(obase);
        checks++;
        if (r != -1) begin
            errors++;
            $display("FAIL t4_bus idx=%0d got=%h exp=%h", r, diff_got, diff_exp);
        end
        checks++;
        if (tick_cnt !== 16'd2 || tick_seen - tbase != 2) begin
            errors++;
            $display("FAIL t4_tick_cnt got=cnt%0d pulses%0d exp=cnt2 pulses2", tick_cnt, tick_seen - tbase);
        end
    endtask

    task automatic test_run_check_err();
        int obase, tbase, acc, r;
        obase = obs_q.size(); tbase = tick_seen;
        force_norun = 1'b1;
        build_exp(32'd20, 0);
        send_cmd(32'd20, 16'd3, acc);
        wait_done(30, "t5");
        force_norun = 1'b0;
        r = bus_diff(obase);
        checks++;
        if (r != -1) begin
            errors++;
            $display("FAIL t5_bus idx=%0d got=%h exp=%h", r, diff_got, diff_exp);
        end
        step(3);
        checks++;
        if (err !== 1'b1 || tick_seen != tbase) begin
            errors++;
            $display("FAIL t5_err_sticky got=err%b pulses%0d exp=err1 pulses0", err, tick_seen - tbase);
        end
        send_cmd(32'd5, 16'd1, acc);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL t5_err_clear got=%b exp=0", err);
        end
        wait_done(40, "t5b");
        checks++;
        if (err !== 1'b0 || tick_cnt !== 16'd1) begin
            errors++;
            $display("FAIL t5_after got=err%b cnt%0d exp=err0 cnt1", err, tick_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int obase, tbase, acc, r;
        tbase = tick_seen;
        send_cmd(32'd20, 16'd0, acc);
        wait_ticks(tbase + 2, 100, "t6");
        step(1);
        reset = 1'b1;
        step(1);
        checks++;
        if (avm_chipselect !== 1'b0 || busy !== 1'b0 || tick_cnt !== '0) begin
            errors++;
            $display("FAIL t6_reset got=cs%b busy%b cnt%0d exp=cs0 busy0 cnt0", avm_chipselect, busy, tick_cnt);
        end
        reset = 1'b0;
        step(1);
        obase = obs_q.size(); tbase = tick_seen;
        build_exp(32'd7, 2);
        send_cmd(32'd7, 16'd2, acc);
        wait_done(60, "t6");
        r = bus_diff(obase);
        checks++;
        if (r != -1) begin
            errors++;
            $display("FAIL t6_bus idx=%0d got=%h exp=%h", r, diff_got, diff_exp);
        end
        checks++;
        if (tick_cnt !== 16'd2 || tick_seen - tbase != 2) begin
            errors++;
            $display("FAIL t6_ticks got=cnt%0d pulses%0d exp=cnt2 pulses2", tick_cnt, tick_seen - tbase);
        end
    endtask

    // stop_req held through set-up is ignored until WAIT_IRQ; wide period exercises period_h
    task automatic test_stop_during_setup();
        int obase, tbase, acc, r;
        logic [31:0] p;
        p = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
        obase = obs_q.size(); tbase = tick_seen;
        build_exp(p, 0);
        stop_req = 1'b1;
        send_cmd(p, 16'd5, acc);
        wait_done(30, "setup_stop");
        stop_req = 1'b0;
        r = bus_diff(obase);
        checks++;
        if (r != -1) begin
            errors++;
            $display("FAIL setup_stop_bus idx=%0d got=%h exp=%h", r, diff_got, diff_exp);
        end
        checks++;
        if (tick_seen != tbase || tick_cnt !== '0) begin
            errors++;
            $display("FAIL setup_stop_ticks got=pulses%0d cnt%0d exp=0 0", tick_seen - tbase, tick_cnt);
        end
    endtask

    task automatic test_random();
        int obase, tbase, acc, r, g, c;
        logic [31:0] p;
        for (int n = 0; n < 6; n++) begin
            p = 32'($urandom_range(0, 12));
            c = $urandom_range(1, 4);
            obase = obs_q.size(); tbase = tick_seen;
            build_exp(p, c);
            send_cmd(p, CNT_W'(c), acc);
            wait_done(c * 14 + 60, "rand");
            r = bus_diff(obase);
            checks++;
            if (r != -1) begin
                errors++;
                $display("FAIL rand_bus run=%0d p=%0d c=%0d idx=%0d got=%h exp=%h", n, p, c, r, diff_got, diff_exp);
            end
            g = first_bad_gap(tbase, int'(eff_period(p)) + 1);
            checks++;
            if (g != 0) begin
                errors++;
                $display("FAIL rand_gap run=%0d got=%0d exp=%0d", n, g, int'(eff_period(p)) + 1);
            end
            checks++;
            if (tick_cnt !== CNT_W'(c) || tick_seen - tbase != c) begin
                errors++;
                $display("FAIL rand_ticks run=%0d got=cnt%0d pulses%0d exp=%0d", n, tick_cnt, tick_seen - tbase, c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period_clamp();
        test_continuous_stop();
        test_stop_beats_irq();
        test_run_check_err();
        test_reset_mid_run();
        test_stop_during_setup();
        test_random();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL tick_done_overlap got=%0d exp=0", overlap);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
